regfile_wr_ctrl: RTL and testbench



---
 rtl/regfile_wr_ctrl.sv | 156 +++++++++++++++
 tb/tb_regfile_wr_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_ctrl.sv
// rtl/regfile_wr_ctrl.sv - write-port sequencer, arbiter and pending-load scoreboard for the RV32I regfile
//
// Purpose: after reset, clears x1..x(NREG-1) one register per cycle. It then
// arbitrates the single regfile write port between the execute writeback and
// the load writeback. It also tracks registers that are waiting for load data
// so that decode can stall on RAW/WAW hazards.
// Optional build macro: REGFILE_WR_RR_EN selects round-robin arbitration on
// contention. Without it, the load writeback always wins on contention.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   init_busy           high while the clear sequence runs
//   ex_valid/ex_ready   execute writeback handshake, with ex_rd/ex_data
//   ld_valid/ld_ready   load writeback handshake, with ld_rd/ld_data
//   ld_issue/ld_issue_rd  a load was issued this cycle, and its destination
//   rs1, rs2, hazard    decode source registers and the resulting stall request
//   pend_mask           bit i set means register i awaits load data
//   rd, rd_in           drive the regfile write port (written every cycle)
module regfile_wr_ctrl #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  output logic            init_busy,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            hazard,
  output logic [NREG-1:0] pend_mask,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] rd_in
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] set_vec, clr_vec;
  logic            run_act;
  logic            elig_ld, elig_ex, contend;
  logic            gnt_ld, gnt_ex;
`ifdef REGFILE_WR_RR_EN
  // 1 means ex won the last contended cycle; 0 means ld won it.
  logic            rr_last_q, rr_last_d;
`endif

  always_comb begin
    // A reset cycle grants nothing, so no handshake completes on it.
    run_act = (state_q == S_RUN) && !reset;
    elig_ld = run_act && ld_valid;
    // Hold ex behind an outstanding load to the same register (WAW order).
    elig_ex = run_act && ex_valid && !((ex_rd != '0) && pend_q[ex_rd]);
    contend = elig_ld && elig_ex;
`ifdef REGFILE_WR_RR_EN
    gnt_ld  = elig_ld && !(contend && !rr_last_q);
    gnt_ex  = elig_ex && !(contend && rr_last_q);
`else
    gnt_ld  = elig_ld;
    gnt_ex  = elig_ex && !elig_ld;
`endif
  end

  assign ex_ready  = gnt_ex;
  assign ld_ready  = gnt_ld;
  assign init_busy = (state_q == S_INIT);
  assign pend_mask = pend_q;

  always_comb begin
    if (state_q == S_INIT) begin
      hazard = 1'b1;
    end else begin
      hazard = ((rs1 != '0) && pend_q[rs1]) || ((rs2 != '0) && pend_q[rs2]);
    end
  end

  // When nothing is granted, x0 is written with zero; the regfile discards it.
  always_comb begin
    rd    = '0;
    rd_in = '0;
    if (state_q == S_INIT) begin
      rd = clr_cnt_q;
    end else if (gnt_ld) begin
      rd    = ld_rd;
      rd_in = ld_data;
    end else if (gnt_ex) begin
      rd    = ex_rd;
      rd_in = ex_data;
    end
  end

  // Scoreboard: a set in the same cycle as a clear of the same bit wins.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (run_act && ld_issue && (ld_issue_rd != '0)) begin
      set_vec[ld_issue_rd] = 1'b1;
    end
    if (gnt_ld) begin
      clr_vec[ld_rd] = 1'b1;
    end
    pend_d    = (pend_q & ~clr_vec) | set_vec;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == S_INIT) begin
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == AW'(NREG - 1)) begin
        state_d = S_RUN;
      end
    end
  end

`ifdef REGFILE_WR_RR_EN
  always_comb begin
    rr_last_d = rr_last_q;
    if (contend) begin
      rr_last_d = gnt_ex;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_INIT;
      clr_cnt_q <= AW'(1);
      pend_q    <= '0;
`ifdef REGFILE_WR_RR_EN
      rr_last_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      pend_q    <= pend_d;
`ifdef REGFILE_WR_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// tb/tb_regfile_wr_ctrl.sv - self-checking bench for regfile_wr_ctrl
module tb_regfile_wr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_busy;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic [4:0]  rs1, rs2;
  logic        hazard;
  logic [31:0] pend_mask;
  logic [4:0]  rd;
  logic [31:0] rd_in;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_wr_ctrl #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .init_busy(init_busy),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .rs1(rs1), .rs2(rs2),
    .hazard(hazard), .pend_mask(pend_mask), .rd(rd), .rd_in(rd_in)
  );

  always #5 clk = ~clk;

  // External regfile driven by the DUT write port.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (rd != 5'd0) rf[rd] <= rd_in;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_known = 1'b0;
  bit          m_run;
  int          m_clr;
  logic [31:0] m_pend;
  bit          m_exlast;          // ex won the last contention
  logic [31:0] m_rf [32];

  logic        e_busy, e_exr, e_ldr, e_haz, e_both;
  logic [4:0]  e_rd;
  logic [31:0] e_rdin, e_pend_nx;

  always @* begin
    e_busy = !m_run;
    e_exr  = 1'b0;
    e_ldr  = 1'b0;
    e_both = 1'b0;
    e_rd   = 5'd0;
    e_rdin = 32'd0;
    e_haz  = 1'b1;
    if (m_run) begin
      e_haz = (rs1 != 0 && m_pend[rs1]) || (rs2 != 0 && m_pend[rs2]);
      if (!reset) begin
        e_both = ld_valid && ex_valid && !(ex_rd != 0 && m_pend[ex_rd]);
        if (e_both) begin
`ifdef REGFILE_WR_RR_EN
          e_exr = !m_exlast;
          e_ldr = m_exlast;
`else
          e_ldr = 1'b1;
`endif
        end else begin
          e_ldr = ld_valid;
          e_exr = ex_valid && !(ex_rd != 0 && m_pend[ex_rd]);
        end
      end
      if (e_ldr) begin e_rd = ld_rd; e_rdin = ld_data; end
      else if (e_exr) begin e_rd = ex_rd; e_rdin = ex_data; end
    end else begin
      e_rd = m_clr[4:0];
    end
    e_pend_nx = m_pend;
    if (e_ldr) e_pend_nx[ld_rd] = 1'b0;
    if (m_run && !reset && ld_issue && ld_issue_rd != 0) e_pend_nx[ld_issue_rd] = 1'b1;
  end

  always @(posedge clk) begin
    if (m_known && e_rd != 5'd0) m_rf[e_rd] <= e_rdin;
    if (reset) begin
      m_known  <= 1'b1;
      m_run    <= 1'b0;
      m_clr    <= 1;
      m_pend   <= 32'd0;
      m_exlast <= 1'b0;
    end else if (m_known) begin
      if (!m_run) begin
        m_clr <= m_clr + 1;
        if (m_clr == 31) m_run <= 1'b1;
      end else begin
        m_pend <= e_pend_nx;
        if (e_both) m_exlast <= e_exr;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("init_busy", {31'd0, init_busy}, {31'd0, e_busy});
      chk("ex_ready",  {31'd0, ex_ready},  {31'd0, e_exr});
      chk("ld_ready",  {31'd0, ld_ready},  {31'd0, e_ldr});
      chk("hazard",    {31'd0, hazard},    {31'd0, e_haz});
      chk("pend_mask", pend_mask, m_pend);
      chk("rd",        {27'd0, rd},        {27'd0, e_rd});
      chk("rd_in",     rd_in, e_rdin);
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (init_busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("init_bound", {31'd0, (n < 100)}, 32'd1);
  endtask

  initial begin
    int  n;
    bit  xe, xl;
    reset = 1'b1; ex_valid = 0; ex_rd = 0; ex_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; ld_issue = 0; ld_issue_rd = 0;
    rs1 = 0; rs2 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Clear sequence: 31 writes of zero, busy drops on cycle 32.
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk("init_rd", {27'd0, rd}, i);
      chk("init_rdin", rd_in, 32'd0);
    end
    @(negedge clk);
    chk("busy_cycle32", {31'd0, init_busy}, 32'd0);
    for (int i = 1; i < 32; i++) chk("rf_cleared", rf[i], 32'd0);

    // Plain ex write.
    nxt(); ex_valid = 1; ex_rd = 5; ex_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("ex_acc", {31'd0, ex_ready}, 32'd1);
    chk("ex_rd5", {27'd0, rd}, 32'd5);
    chk("ex_data", rd_in, 32'hDEADBEEF);
    nxt(); ex_valid = 0;
    @(negedge clk);
    chk("rf_x5", rf[5], 32'hDEADBEEF);
    chk("idle_rd", {27'd0, rd}, 32'd0);

    // Pending load on x7 gates decode and ex.
    nxt(); ld_issue = 1; ld_issue_rd = 7;
    nxt(); ld_issue = 0; rs1 = 7; ex_valid = 1; ex_rd = 7; ex_data = 32'h0000AAAA;
    @(negedge clk);
    chk("pend_x7", pend_mask, 32'h80);
    chk("haz_x7", {31'd0, hazard}, 32'd1);
    chk("ex_held", {31'd0, ex_ready}, 32'd0);
    nxt(); ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
    @(negedge clk);
    chk("ld_acc", {31'd0, ld_ready}, 32'd1);
    chk("ld_rdin", rd_in, 32'h1234);
    nxt(); ld_valid = 0;
    @(negedge clk);
    chk("pend_clr", pend_mask, 32'd0);
    chk("haz_clr", {31'd0, hazard}, 32'd0);
    chk("ex_after", {31'd0, ex_ready}, 32'd1);
    nxt(); ex_valid = 0; rs1 = 0;

    // Contention for 4 cycles.
    ex_valid = 1; ex_rd = 9; ex_data = 32'h99; ld_valid = 1; ld_rd = 10; ld_data = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef REGFILE_WR_RR_EN
      chk("rr_ex", {31'd0, ex_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ld", {31'd0, ld_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
`else
      chk("fix_ex", {31'd0, ex_ready}, 32'd0);
      chk("fix_ld", {31'd0, ld_ready}, 32'd1);
`endif
      nxt();
    end
    ex_valid = 0; ld_valid = 0;

    // Set wins over clear on the same register; x0 issue is ignored.
    ld_issue = 1; ld_issue_rd = 3; ld_valid = 1; ld_rd = 3; ld_data = 32'h33;
    @(negedge clk);
    chk("setclr_acc", {31'd0, ld_ready}, 32'd1);
    nxt(); ld_valid = 0; ld_issue_rd = 0;
    @(negedge clk);
    chk("set_wins", pend_mask, 32'h8);
    nxt(); ld_issue = 0;
    @(negedge clk);
    chk("x0_issue", pend_mask, 32'h8);
    nxt(); ld_valid = 1; ld_rd = 3;
    nxt(); ld_valid = 0;

    // Reset in the middle of the clear sequence.
    reset = 1;
    nxt(); reset = 0;
    @(negedge clk);
    chk("reinit_rd1", {27'd0, rd}, 32'd1);
    repeat (11) nxt();
    @(negedge clk);
    chk("clr12", {27'd0, rd}, 32'd12);
    nxt(); reset = 1;
    @(negedge clk);
    chk("rst_busy", {31'd0, init_busy}, 32'd1);
    nxt(); reset = 0;
    @(negedge clk);
    chk("restart_rd1", {27'd0, rd}, 32'd1);
    wait_run(n);
    chk("reinit_len", n, 32'd31);

    // Reset during an ex handshake.
    nxt(); ld_issue = 1; ld_issue_rd = 4;
    nxt(); ld_issue = 0; ex_valid = 1; ex_rd = 6; ex_data = 32'h66; reset = 1;
    @(negedge clk);
    chk("rst_no_ready", {31'd0, ex_ready}, 32'd0);
    nxt(); reset = 0; ex_valid = 0;
    @(negedge clk);
    chk("rst_pend", pend_mask, 32'd0);
    chk("rst_rd1", {27'd0, rd}, 32'd1);
    wait_run(n);

    // Randomised traffic obeying hold-until-ready.
    nxt();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      xe = ex_valid && ex_ready;
      xl = ld_valid && ld_ready;
      @(posedge clk);
      #1;
      if (!ex_valid || xe) begin
        ex_valid = ($urandom_range(2) != 0);
        ex_rd    = 5'($urandom_range(7));
        ex_data  = $urandom;
      end
      if (!ld_valid || xl) begin
        ld_valid = ($urandom_range(1) != 0);
        ld_rd    = 5'($urandom_range(7));
        ld_data  = $urandom;
      end
      ld_issue    = ($urandom_range(3) == 0);
      ld_issue_rd = 5'($urandom_range(7));
      rs1         = 5'($urandom_range(7));
      rs2         = 5'($urandom_range(7));
      reset       = ($urandom_range(499) == 0);
    end
    reset = 0; ex_valid = 0; ld_valid = 0; ld_issue = 0;
    @(negedge clk);
    wait_run(n);
    for (int i = 1; i < 32; i++) chk("rf_final", rf[i], m_rf[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
